// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop framing with a 2-flop input
// synchronizer, one-cycle done / framing-error pulses and a held data word.
//
//   state | meaning
//   IDLE  | line idle, waiting for rx to fall
//   START | counting to the start-bit midpoint, rejecting glitches
//   DATA  | sampling DATA_BITS bits, LSB first, one per 16 ticks
//   STOP  | waiting SB_TICK ticks, then judging the stop bit
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] S_ONE  = S_W'(1);
    localparam logic [S_W-1:0] S_MID  = S_W'(7);
    localparam logic [S_W-1:0] S_BIT  = S_W'(15);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_ONE  = N_W'(1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [S_W-1:0]       s;
    logic [N_W-1:0]       n;
    logic [DATA_BITS-1:0] b;
    logic [DATA_BITS-1:0] b_shift;
    logic                 rx_meta;
    logic                 rx_sync;

    // Synchronizer flops reset to the idle (high) line level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    assign b_shift = {rx_sync, b[DATA_BITS-1:1]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (s == S_MID) begin
                            s <= '0;
                            n <= '0;
                            state <= rx_sync ? IDLE : DATA;
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (s == S_BIT) begin
                            s <= '0;
                            b <= b_shift;
                            if (n == N_LAST) begin
                                o_data <= b_shift;
                                state  <= STOP;
                            end else begin
                                n <= n + N_ONE;
                            end
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
                STOP: begin
                    // A falling edge here is not a start bit until IDLE sees it.
                    if (i_tick) begin
                        if (s == S_STOP) begin
                            state       <= IDLE;
                            o_rx_done   <= rx_sync;
                            o_frame_err <= !rx_sync;
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 The block SHALL have parameter SB_TICK, default 16, number of ticks in the stop bit (16 = 1 stop bit at 16x oversampling).
REQ-003 Port i_clock  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 Port i_reset  input  1  synchronous, active-high reset.
REQ-005 Port i_tick  input  1  one-cycle pulse at 16x baud rate, from the baud rate generator o_tick.
REQ-006 Port i_rx  input  1  serial line, asynchronous, idle high.
REQ-007 Port o_data  output  DATA_BITS  last received data word, LSB received first.
REQ-008 Port o_rx_done  output  1  one-cycle pulse when a frame with a valid stop bit completes.
REQ-009 Port o_frame_err  output  1  one-cycle pulse when a frame completes with stop bit sampled low.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer; "rx" below means the synchronizer output; the synchronizer adds exactly 2 clock cycles of latency.
REQ-011 Control SHALL be a 4-state FSM: IDLE, START, DATA, STOP.
REQ-012 Internal registers: tick counter s (4 bits, min), bit counter n (ceil(log2(DATA_BITS)) bits), shift register b (DATA_BITS bits).
REQ-013 IDLE: when rx = 0, go to START with s = 0; i_tick is ignored in IDLE.
REQ-014 START: on i_tick with s = 7, if rx = 0 go to DATA with s = 0, n = 0; if rx = 1 (glitch), return to IDLE without any output pulse; otherwise on i_tick s increments.
REQ-015 DATA: on i_tick with s = 15, b = {rx, b[DATA_BITS-1:1]}, s = 0; if n = DATA_BITS-1 go to STOP, else n increments; otherwise on i_tick s increments.
REQ-016 STOP: on i_tick with s = SB_TICK-1, go to IDLE; if rx = 1 pulse o_rx_done, else pulse o_frame_err; otherwise on i_tick s increments.
REQ-017 o_data SHALL be driven from b and updated only on the clock completing the final DATA shift; it SHALL hold its value through STOP, IDLE and subsequent frames until the next last-bit shift.
REQ-018 o_rx_done and o_frame_err SHALL be registered, high for exactly one i_clock cycle, and never high simultaneously.
REQ-019 Cycles without i_tick SHALL leave s, n, b and state unchanged, except the IDLE→START transition.
REQ-020 A new falling edge during STOP SHALL be ignored; a new frame is detected only after returning to IDLE.
REQ-021 With no tick gaps, a frame SHALL complete (pulse) 8 + 16·DATA_BITS + SB_TICK ticks after START entry.

Reset
REQ-022 On i_reset = 1 at a rising edge: state = IDLE, s = 0, n = 0, b = 0, o_data = 0, o_rx_done = 0, o_frame_err = 0, both synchronizer flops = 1.
REQ-023 Reset SHALL take priority over all other activity, including mid-frame; the partial frame is discarded with no pulse.
REQ-024 After reset release the block SHALL accept a start bit on the next falling edge of rx.

Verification
REQ-025 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 ticks/bit, i_tick every 4 clocks -> one o_rx_done pulse, o_data = 0xA5, o_frame_err stays 0.
REQ-026 Low glitch of 4 ticks on idle line -> FSM returns to IDLE at START s = 7, no pulses, o_data unchanged.
REQ-027 Frame 0x3C with stop bit driven 0 -> one o_frame_err pulse, no o_rx_done, o_data = 0x3C.
REQ-028 Back-to-back frames 0x00 then 0xFF, no idle gap -> two o_rx_done pulses, o_data = 0x00 then 0xFF.
REQ-029 i_reset asserted for 1 cycle during DATA bit 4 of frame 0x55, then frame 0x81 sent -> no pulse for the aborted frame, then o_rx_done with o_data = 0x81.
REQ-030 With br_gen at 25 MHz / 19200 baud×16 driving i_tick, frame 0x5A -> o_rx_done, o_data = 0x5A, pulse within one bit time after stop bit mid-point.
